// File: rtl/fp_sqrt_sequencer_if.sv
// Control/status bundle between a square-root requester and fp_sqrt_sequencer.
interface fp_sqrt_sequencer_if #(
   parameter int unsigned CW_WIDTH = 14
);
   logic                start_i;
   logic                special_i;
   logic                abort_i;
   logic                converged_i;
   logic [CW_WIDTH-1:0] ctrl_o;
   logic                busy_o;
   logic                done_o;
   logic [3:0]          iter_o;

   // Requester side: issues operations, observes control word and status.
   modport master (
      output start_i, special_i, abort_i, converged_i,
      input  ctrl_o, busy_o, done_o, iter_o
   );

   // Sequencer side.
   modport slave (
      input  start_i, special_i, abort_i, converged_i,
      output ctrl_o, busy_o, done_o, iter_o
   );
endinterface

// File: rtl/fp_sqrt_sequencer.sv
// Newton-iteration sequencer for a floating-point square-root datapath.
// Walks LOAD/INIT, then ITERATIONS passes of P0..P3 (last pass skips P3),
// then OUT/DONE. Special operands short-cut LOAD -> OUT.
// Optional feature macro: SQRT_EARLY_EXIT_EN (exit from P3 on converged_i).
module fp_sqrt_sequencer #(
   parameter int unsigned ITERATIONS = 12,
   parameter int unsigned CW_WIDTH   = 14
) (
   input logic                 Clk,
   input logic                 Reset,
   fp_sqrt_sequencer_if.slave  bus
);

   localparam int unsigned CNT_W     = 4;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LOAD = 4'd1,
      S_INIT = 4'd2,
      S_P0   = 4'd3,
      S_P1   = 4'd4,
      S_P2   = 4'd5,
      S_P3   = 4'd6,
      S_OUT  = 4'd7,
      S_DONE = 4'd8
   } state_t;

   state_t           state;
   state_t           nxt_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt_cnt;

   // Datapath control word for each state.
   function automatic logic [13:0] ctrl_of(input state_t s);
      case (s)
         S_LOAD:  return 14'b11001000000000;
         S_INIT:  return 14'b01010001000000;
         S_P0:    return 14'b01011001010100;
         S_P1:    return 14'b01011011010000;
         S_P2:    return 14'b01011011101100;
         S_P3:    return 14'b01010011000000;
         S_OUT:   return 14'b00111011000001;
         default: return 14'b00000000000000;
      endcase
   endfunction

   function automatic logic in_pass(input state_t s);
      return (s == S_P0) || (s == S_P1) || (s == S_P2) || (s == S_P3);
   endfunction

`ifndef SQRT_EARLY_EXIT_EN
   logic unused_converged;
   assign unused_converged = bus.converged_i;
`endif

   // Next state and iteration counter; abort overrides everything when busy.
   always_comb begin
      nxt_state = S_IDLE;
      nxt_cnt   = cnt;
      case (state)
         S_IDLE: nxt_state = bus.start_i ? S_LOAD : S_IDLE;
         S_LOAD: nxt_state = bus.special_i ? S_OUT : S_INIT;
         S_INIT: begin
            nxt_state = S_P0;
            nxt_cnt   = '0;
         end
         S_P0:   nxt_state = S_P1;
         S_P1:   nxt_state = S_P2;
         S_P2:   nxt_state = (cnt == LAST_ITER) ? S_OUT : S_P3;
         S_P3: begin
`ifdef SQRT_EARLY_EXIT_EN
            if (bus.converged_i) begin
               nxt_state = S_OUT;
            end else begin
               nxt_state = S_P0;
               nxt_cnt   = CNT_W'(cnt + CNT_W'(1));
            end
`else
            nxt_state = S_P0;
            nxt_cnt   = CNT_W'(cnt + CNT_W'(1));
`endif
         end
         S_OUT:  nxt_state = S_DONE;
         S_DONE: nxt_state = S_IDLE;
         default: begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
         end
      endcase
      if ((state != S_IDLE) && bus.abort_i) begin
         nxt_state = S_IDLE;
         nxt_cnt   = '0;
      end
   end

   // State register; outputs registered from the next state so they track state exactly.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bus.ctrl_o <= '0;
         bus.busy_o <= 1'b0;
         bus.done_o <= 1'b0;
         bus.iter_o <= '0;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         bus.ctrl_o <= CW_WIDTH'(ctrl_of(nxt_state));
         bus.busy_o <= (nxt_state != S_IDLE);
         bus.done_o <= (nxt_state == S_DONE);
         bus.iter_o <= in_pass(nxt_state) ? nxt_cnt : '0;
      end
   end

endmodule
